// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, optional parity, 1/2 stop bits.
// Each bit is sampled at its midpoint using an OVS-times oversampling strobe.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 os_stb,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    localparam logic [OW-1:0] OS_MID    = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OS_END    = OW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_FLIP  = (PARITY_ODD != 0);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [OW-1:0]        r_os_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_dout_vld;
    logic                 r_frame_err;
    logic                 r_parity_err;

    logic w_rxd_s;
    logic w_os_end;
    logic w_par_err;

    assign w_rxd_s   = r_sync2;
    assign w_os_end  = (r_os_cnt == OS_END);
    assign w_par_err = (^r_shift) ^ w_rxd_s ^ ODD_FLIP;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= S_IDLE;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_dout       <= '0;
            r_dout_vld   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_dout_vld <= 1'b0;
            if (os_stb) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rxd_s) begin
                            r_state  <= S_START;
                            r_os_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (r_os_cnt == OS_MID) begin
                            r_os_cnt <= '0;
                            if (!w_rxd_s) begin
                                r_state    <= S_DATA;
                                r_bit_cnt  <= '0;
                                r_stop_cnt <= 1'b0;
                                r_ferr     <= 1'b0;
                                r_perr     <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OW'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_os_end) begin
                            r_os_cnt  <= '0;
                            r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                            if (r_bit_cnt == BIT_LAST)
                                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + OW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (w_os_end) begin
                            r_os_cnt <= '0;
                            r_perr   <= w_par_err;
                            r_state  <= S_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + OW'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_os_end) begin
                            r_os_cnt <= '0;
                            // Final stop sampled at mid-bit: publish now so a back-to-back start edge is caught.
                            if (r_stop_cnt == STOP_LAST) begin
                                r_dout       <= r_shift;
                                r_frame_err  <= r_ferr | ~w_rxd_s;
                                r_parity_err <= r_perr;
                                r_dout_vld   <= 1'b1;
                                r_state      <= w_rxd_s ? S_IDLE : S_BREAK;
                            end else begin
                                r_ferr     <= ~w_rxd_s;
                                r_stop_cnt <= 1'b1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OW'(1);
                        end
                    end
                    S_BREAK: begin
                        if (w_rxd_s)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign dout       = r_dout;
    assign dout_vld   = r_dout_vld;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: four instances (8N1, 7E1, 8N2, 9N1) share clk/os_stb/rstn.
module tb_uart_rx_cfg;

    localparam int OVS = 16;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk;
    logic rstn;
    logic os_stb;
    logic rxd [4];

    logic [7:0] d8;
    logic [6:0] d7;
    logic [7:0] d2;
    logic [8:0] d9;
    logic       vld  [4];
    logic       fe   [4];
    logic       pe   [4];
    logic       bsy  [4];
    logic [8:0] dw   [4];

    exp_t sb [4][$];
    int   checks;
    int   errors;
    int   nv [4];

    uart_rx_cfg u8 (
        .clk(clk), .rstn(rstn), .os_stb(os_stb), .rxd(rxd[0]),
        .dout(d8), .dout_vld(vld[0]), .frame_err(fe[0]), .parity_err(pe[0]), .busy(bsy[0])
    );
    uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u7p (
        .clk(clk), .rstn(rstn), .os_stb(os_stb), .rxd(rxd[1]),
        .dout(d7), .dout_vld(vld[1]), .frame_err(fe[1]), .parity_err(pe[1]), .busy(bsy[1])
    );
    uart_rx_cfg #(.STOP_BITS(2)) u2s (
        .clk(clk), .rstn(rstn), .os_stb(os_stb), .rxd(rxd[2]),
        .dout(d2), .dout_vld(vld[2]), .frame_err(fe[2]), .parity_err(pe[2]), .busy(bsy[2])
    );
    uart_rx_cfg #(.DATA_BITS(9)) u9 (
        .clk(clk), .rstn(rstn), .os_stb(os_stb), .rxd(rxd[3]),
        .dout(d9), .dout_vld(vld[3]), .frame_err(fe[3]), .parity_err(pe[3]), .busy(bsy[3])
    );

    assign dw[0] = {1'b0, d8};
    assign dw[1] = {2'b00, d7};
    assign dw[2] = {1'b0, d2};
    assign dw[3] = d9;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every two clocks, so one bit period is 2*OVS clocks.
    initial begin
        os_stb = 1'b0;
        forever begin
            @(negedge clk);
            os_stb = ~os_stb;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i] === 1'b1) begin
                exp_t e;
                nv[i]++;
                checks++;
                if (sb[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_vld[%0d]: got dout=%h with no frame expected", i, dw[i]);
                end else begin
                    e = sb[i].pop_front();
                    if (dw[i] !== e.data) begin
                        errors++;
                        $display("FAIL dout[%0d]: got %h expected %h", i, dw[i], e.data);
                    end
                    checks++;
                    if ({fe[i], pe[i]} !== {e.ferr, e.perr}) begin
                        errors++;
                        $display("FAIL flags[%0d]: got ferr=%b perr=%b expected ferr=%b perr=%b",
                                 i, fe[i], pe[i], e.ferr, e.perr);
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit pen, input bit pbit, input int nstop,
                              input logic [1:0] stops);
        exp_t e;
        logic b [14];
        int   n;
        logic ones;
        n    = 0;
        ones = 1'b0;
        e.data = '0;
        b[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin
            b[n] = data[i]; n++;
            e.data[i] = data[i];
            ones = ones ^ data[i];
        end
        if (pen) begin
            b[n] = pbit; n++;
        end
        for (int i = 0; i < nstop; i++) begin
            b[n] = stops[i]; n++;
        end
        e.ferr = (nstop == 2) ? ~(stops[0] & stops[1]) : ~stops[0];
        e.perr = pen ? (ones ^ pbit) : 1'b0;
        sb[sel].push_back(e);
        for (int k = 0; k < n; k++) begin
            rxd[sel] = b[k];
            wait_clks(OVS);
            if (k < n - 1) begin
                checks++;
                if (bsy[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid[%0d] bit %0d: got %b expected 1", sel, k, bsy[sel]);
                end
            end
            wait_clks(OVS);
        end
    endtask

    task automatic wait_drain(input int sel);
        int t;
        t = 0;
        while (sb[sel].size() != 0 && t < 4 * OVS) begin
            wait_clks(1);
            t++;
        end
        checks++;
        if (sb[sel].size() != 0) begin
            errors++;
            $display("FAIL drain[%0d]: %0d frames outstanding, expected 0", sel, sb[sel].size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({dw[i], vld[i], fe[i], pe[i], bsy[i]} !== 13'd0) begin
                errors++;
                $display("FAIL %s[%0d]: got dout=%h vld=%b fe=%b pe=%b busy=%b expected all 0",
                         tag, i, dw[i], vld[i], fe[i], pe[i], bsy[i]);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) rxd[i] = 1'b1;
        wait_clks(4);
        rstn = 1'b1;
        check_idle_outputs("reset");
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = nv[0];
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0);
        checks++;
        if (nv[0] !== n0 + 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses expected %0d", nv[0] - n0, 2);
        end
    endtask

    task automatic test_glitch();
        int n0;
        int t;
        n0 = nv[0];
        wait_clks(2 * OVS);
        rxd[0] = 1'b0;
        wait_clks(2 * 4);
        checks++;
        if (bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_detect: busy got %b expected 1", bsy[0]);
        end
        rxd[0] = 1'b1;
        t = 0;
        while (bsy[0] !== 1'b0 && t < 2 * (OVS / 2 + 1)) begin
            wait_clks(1);
            t++;
        end
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: busy got %b expected 0 within %0d ticks", bsy[0], OVS / 2 + 1);
        end
        wait_clks(4 * OVS);
        checks++;
        if (nv[0] !== n0) begin
            errors++;
            $display("FAIL glitch_novld: got %0d pulses expected 0", nv[0] - n0);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 9'h041, 7, 1'b1, 1'b0, 1, 2'b11);
        send_frame(1, 9'h041, 7, 1'b1, 1'b1, 1, 2'b11);
        wait_drain(1);
    endtask

    task automatic test_break();
        int n0;
        n0 = nv[2];
        send_frame(2, 9'h055, 8, 1'b0, 1'b0, 2, 2'b01);
        wait_drain(2);
        wait_clks(30 * 2 * OVS);
        checks++;
        if (nv[2] !== n0 + 1) begin
            errors++;
            $display("FAIL break_single: got %0d pulses expected 1", nv[2] - n0);
        end
        checks++;
        if (bsy[2] !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b expected 1", bsy[2]);
        end
        rxd[2] = 1'b1;
        wait_clks(2 * OVS);
        checks++;
        if (bsy[2] !== 1'b0) begin
            errors++;
            $display("FAIL break_release: busy got %b expected 0", bsy[2]);
        end
        send_frame(2, 9'h012, 8, 1'b0, 1'b0, 2, 2'b11);
        wait_drain(2);
    endtask

    task automatic test_nine_bits();
        send_frame(3, 9'h1FF, 9, 1'b0, 1'b0, 1, 2'b11);
        send_frame(3, 9'h100, 9, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(3);
    endtask

    task automatic test_reset_midframe();
        int n0;
        n0 = nv[0];
        wait_clks(2 * OVS);
        rxd[0] = 1'b0;
        wait_clks(2 * OVS);
        rxd[0] = 1'b1;
        wait_clks(2 * OVS);
        wait_clks(OVS);
        rstn = 1'b0;
        wait_clks(1);
        rstn = 1'b1;
        check_idle_outputs("midreset");
        wait_clks(4 * 2 * OVS);
        checks++;
        if (nv[0] !== n0) begin
            errors++;
            $display("FAIL midreset_novld: got %0d pulses expected 0", nv[0] - n0);
        end
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 2'b11);
        wait_drain(0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) nv[i] = 0;
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) rxd[i] = 1'b1;
        wait_clks(2);
        test_reset();
        test_back_to_back();
        test_glitch();
        test_parity();
        test_break();
        test_nine_bits();
        test_reset_midframe();
        for (int i = 0; i < 4; i++) wait_drain(i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, optional parity and 1/2 stop bits. Samples each bit at its midpoint using an oversampling strobe from the shared baud generator, and flags false starts, framing and parity errors. Sits between the pad-side rxd input and the RX FIFO / register interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB received first.
OVS, 16, os_stb ticks per bit period; even, >= 4.
PARITY_EN, 0, 1 = parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits checked; 1 or 2.

Ports:
clk  in  1  system clock.
rstn  in  1  reset; synchronous to clk, active-low.
os_stb  in  1  one-clk oversample tick at OVS x baud rate.
rxd  in  1  asynchronous serial input; idle high.
dout  out  DATA_BITS  last received data word.
dout_vld  out  1  one-clk pulse: dout, frame_err and parity_err are updated.
frame_err  out  1  a checked stop bit of the last frame was sampled low.
parity_err  out  1  parity mismatch in the last frame; always 0 when PARITY_EN = 0.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstn low at a clk edge): all outputs 0; FSM to IDLE; counters 0; both synchroniser flops 1. Reset applies mid-frame; the partial frame is discarded and no dout_vld is produced.
- rxd passes through a 2-flop synchroniser to give rxd_s. All decisions use rxd_s.
- The FSM and counters advance only on clk edges where os_stb = 1. The exception is dout_vld, which is a 1-clk pulse.
- State counters: os_cnt, width clog2(OVS), counts ticks within a bit. bit_cnt counts data bits.
- IDLE: if os_stb and rxd_s = 0, go to START with os_cnt = 0.
- START: os_cnt increments each tick. At os_cnt = OVS/2-1 (mid start bit), check rxd_s:
  - rxd_s = 0: go to DATA with os_cnt = 0 and bit_cnt = 0.
  - rxd_s = 1 (false start/glitch): go to IDLE, no output.
- DATA: at os_cnt = OVS-1, shift rxd_s into the MSB of the shift register (right shift), set os_cnt = 0 and increment bit_cnt. After the DATA_BITS-th sample, go to PARITY if PARITY_EN = 1, else to STOP. Sample points therefore fall on bit midpoints.
- PARITY: at os_cnt = OVS-1, sample the parity bit. The error is the XOR of the data bits and the parity bit, inverted when PARITY_ODD = 1. Then go to STOP.
- STOP: sample at os_cnt = OVS-1. When STOP_BITS = 2, both stop bits are sampled. frame_err for the frame is the OR of the sampled-low results.
- On the tick that samples the final stop bit:
  - dout is loaded with the shift register.
  - frame_err and parity_err are updated.
  - dout_vld is asserted on the next clk.
  - The FSM goes to IDLE if the stop bit is high, or to BREAK if it is low.
- Returning to IDLE at mid stop bit allows back-to-back frames with no idle gap.
- BREAK: stay until a tick with rxd_s = 1, then go to IDLE. A held-low line therefore yields exactly one frame_err frame, not repeated frames.
- Frame latency: dout_vld rises 1 clk after the os_stb that samples the mid-point of the last stop bit.
- dout, frame_err and parity_err hold their values until the next dout_vld. Erroneous frames still update dout.
- os_stb = 0 at the moment rxd changes has no effect. A start edge is detected on the first tick that sees rxd_s low.

Test Plan:
- Defaults (8N1, OVS = 16): send 0xA5 then 0x3C back-to-back (no idle) -> two dout_vld pulses, dout = 0xA5 then 0x3C, frame_err = parity_err = 0, busy high throughout both frames.
- Glitch: rxd low for 4 ticks, then high -> no dout_vld, FSM returns to IDLE, busy low again within OVS/2+1 ticks.
- PARITY_EN = 1, PARITY_ODD = 0, DATA_BITS = 7: send 0x41 with parity bit 0, then with parity bit 1 -> parity_err = 0 then 1, dout = 0x41 both times.
- STOP_BITS = 2: send 0x55 with the second stop bit low -> dout_vld, dout = 0x55, frame_err = 1. Then hold rxd low 30 bit-times -> no further dout_vld. Release high, send 0x12 -> dout = 0x12, frame_err = 0.
- DATA_BITS = 9: send 0x1FF then 0x100 -> dout = 0x1FF, 0x100.
- Assert rstn low mid-DATA of 0x77 for 1 clk -> all outputs 0, no dout_vld. The next frame, 0x81, is received correctly.
